// File: rtl/tx_level_gen_pkg.sv
// Shared definitions for the 4-ASK transmit level generator.
// Holds the amplitude constants, the FSM state type, the maximal-length LFSR tap table
// and the Gray symbol-to-amplitude map, which the receive slicer also uses.
package tx_level_gen_pkg;

  localparam int LFSR_LEN_DEF = 4;

  // Signed 1s17 amplitudes: 0.75 and 0.25
  localparam logic signed [17:0] OUTER_LEVEL = 18'sd98304;
  localparam logic signed [17:0] INNER_LEVEL = 18'sd32768;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  // Feedback tap mask for a maximal-length Fibonacci LFSR (bit k-1 set for tap k).
  // Every entry has an even tap count, so the all-ones seed steps to a value with bit0=0.
  function automatic logic [21:0] lfsr_taps(input int len);
    logic [21:0] mask;
    case (len)
      4:       mask = 22'h00000C;
      5:       mask = 22'h000014;
      6:       mask = 22'h000030;
      7:       mask = 22'h000060;
      8:       mask = 22'h0000B8;
      9:       mask = 22'h000110;
      10:      mask = 22'h000240;
      11:      mask = 22'h000500;
      12:      mask = 22'h000829;
      13:      mask = 22'h00100D;
      14:      mask = 22'h002015;
      15:      mask = 22'h006000;
      16:      mask = 22'h00D008;
      17:      mask = 22'h012000;
      18:      mask = 22'h020400;
      19:      mask = 22'h040023;
      20:      mask = 22'h090000;
      21:      mask = 22'h140000;
      22:      mask = 22'h300000;
      default: mask = 22'h00000C;
    endcase
    return mask;
  endfunction

  // Gray map: 00 -> -OUTER, 01 -> -INNER, 11 -> +INNER, 10 -> +OUTER
  function automatic logic signed [17:0] map_sym(input logic [1:0] sym);
    logic signed [17:0] amp;
    case (sym)
      2'b00:   amp = -OUTER_LEVEL;
      2'b01:   amp = -INNER_LEVEL;
      2'b11:   amp = INNER_LEVEL;
      2'b10:   amp = OUTER_LEVEL;
      default: amp = 18'sd0;
    endcase
    return amp;
  endfunction

endpackage

// File: rtl/tx_level_gen_lfsr.sv
// Fibonacci LFSR used as the pseudo-random symbol source.
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset (seeds the register to all ones)
//   i_step          advance one state
//   o_next_lsb      two LSBs of the value the register loads on the next step
module tx_level_gen_lfsr
  import tx_level_gen_pkg::*;
#(
  parameter int N = LFSR_LEN_DEF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_step,
  output logic [1:0] o_next_lsb
);

  localparam logic [21:0] TAPS = lfsr_taps(N);

  logic [N-1:0] r_q;
  logic [N-1:0] w_next;
  logic         w_fb;

  // Shift toward the MSB, feedback enters bit 0
  always_comb begin
    w_fb   = ^(r_q & TAPS[N-1:0]);
    w_next = {r_q[N-2:0], w_fb};
  end

  assign o_next_lsb = w_next[1:0];

  // Shift register; all-ones seed keeps it off the lock-up state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= {N{1'b1}};
    end else if (i_step) begin
      r_q <= w_next;
    end else begin
      r_q <= r_q;
    end
  end

endmodule

// File: rtl/tx_level_gen.sv
// 4-ASK transmit symbol source: a 2^LFSR_LEN-symbol pseudo-random calibration burst,
// then Gray-mapped user symbols (LFSR filler when no data is offered).
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   clk_en        symbol-rate enable; all state advances only when high
//   start         burst request pulse, remembered until consumed
//   data_sym      Gray-coded user symbol, data_valid qualifies it
//   data_ready    clk_en && state==DATA (combinational)
//   tx_sym        registered signed 1s17 amplitude
//   train_active  registered, high while in TRAIN
//   train_done    registered pulse with the final training symbol
module tx_level_gen
  import tx_level_gen_pkg::*;
#(
  parameter int LFSR_LEN = LFSR_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic [1:0]         data_sym,
  input  logic               data_valid,
  output logic               data_ready,
  output logic signed [17:0] tx_sym,
  output logic               train_active,
  output logic               train_done
);

  localparam logic [LFSR_LEN:0] LAST_CNT = {1'b0, {LFSR_LEN{1'b1}}};

  state_t             r_state;
  logic [LFSR_LEN:0]  r_count;
  logic               r_start_pend;
  logic signed [17:0] r_tx_sym;
  logic               r_train_active;
  logic               r_train_done;

  logic [1:0] w_lfsr_lsb;
  logic       w_step;
  logic       w_pend_clr;

  // The LFSR runs on every enabled cycle outside IDLE, so DATA filler keeps it moving
  assign w_step = clk_en && (r_state != ST_IDLE);

  // A pending start is used up in IDLE/DATA; one arriving during TRAIN is dropped when
  // the burst finishes so it cannot restart the burst
  assign w_pend_clr = clk_en && ((r_state != ST_TRAIN) || (r_count == LAST_CNT));

  tx_level_gen_lfsr #(.N(LFSR_LEN)) u_lfsr (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_step     (w_step),
    .o_next_lsb (w_lfsr_lsb)
  );

  // FSM, burst counter, start latch and output registers.
  // Symbols use the LFSR value loaded on the same edge, so a burst from the all-ones
  // seed covers every state once plus the first again, giving equal outer/inner counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_start_pend   <= 1'b0;
      r_tx_sym       <= 18'sd0;
      r_train_active <= 1'b0;
      r_train_done   <= 1'b0;
    end else begin
      r_start_pend <= start | (r_start_pend & ~w_pend_clr);
      r_train_done <= 1'b0;
      if (clk_en) begin
        case (r_state)
          ST_IDLE: begin
            r_tx_sym <= 18'sd0;
            if (r_start_pend) begin
              r_state        <= ST_TRAIN;
              r_count        <= '0;
              r_train_active <= 1'b1;
            end
          end
          ST_TRAIN: begin
            r_tx_sym <= map_sym(w_lfsr_lsb);
            if (r_count == LAST_CNT) begin
              r_state        <= ST_DATA;
              r_train_done   <= 1'b1;
              r_train_active <= 1'b0;
            end else begin
              r_count <= r_count + {{LFSR_LEN{1'b0}}, 1'b1};
            end
          end
          ST_DATA: begin
            if (r_start_pend) begin
              r_state        <= ST_TRAIN;
              r_count        <= '0;
              r_train_active <= 1'b1;
              r_tx_sym       <= map_sym(w_lfsr_lsb);
            end else if (data_valid) begin
              r_tx_sym <= map_sym(data_sym);
            end else begin
              r_tx_sym <= map_sym(w_lfsr_lsb);
            end
          end
          default: begin
            r_state        <= ST_IDLE;
            r_tx_sym       <= 18'sd0;
            r_train_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_ready   = clk_en && (r_state == ST_DATA);
  assign tx_sym       = r_tx_sym;
  assign train_active = r_train_active;
  assign train_done   = r_train_done;

endmodule

// File: tb/tb_tx_level_gen.sv
// Self-checking bench for tx_level_gen (LFSR_LEN = 4) with a behavioural reference model.
module tb_tx_level_gen;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clk_en = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         data_sym = 2'b00;
  logic               data_valid = 1'b0;
  logic               data_ready;
  logic signed [17:0] tx_sym;
  logic               train_active;
  logic               train_done;

  tx_level_gen #(.LFSR_LEN(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .start        (start),
    .data_sym     (data_sym),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .tx_sym       (tx_sym),
    .train_active (train_active),
    .train_done   (train_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=idle 1=training 2=data; burst tracked as symbols remaining
  int       m_mode = 0;
  bit       m_pend = 1'b0;
  int       m_left = 0;
  bit [3:0] m_win  = 4'hF;  // last four bits of the sequence s[t] = s[t-4] ^ s[t-3]
  int       e_sym  = 0;
  bit       e_act  = 1'b0;
  bit       e_done = 1'b0;

  // Burst statistics gathered from observed outputs
  int g_n = 0;
  int g_sum = 0;
  int g_done = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int amp_of(input bit [1:0] s);
    case (s)
      2'b00:   return -98304;
      2'b01:   return -32768;
      2'b11:   return 32768;
      default: return 98304;
    endcase
  endfunction

  function automatic bit [3:0] seq_next(input bit [3:0] w);
    return {w[2:0], w[3] ^ w[2]};
  endfunction

  task automatic gclr();
    g_n = 0; g_sum = 0; g_done = 0;
  endtask

  task automatic cyc(input bit en, input bit st, input bit [1:0] ds, input bit dv, input bit rs);
    bit was_train;
    @(negedge clk);
    clk_en = en; start = st; data_sym = ds; data_valid = dv; reset = rs;
    #1;
    check_val("data_ready", int'(data_ready), int'(en && (m_mode == 2)));
    @(posedge clk);
    was_train = 1'b0;
    if (rs) begin
      m_mode = 0; m_pend = 1'b0; m_left = 0; m_win = 4'hF;
      e_sym = 0; e_act = 1'b0; e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      if (en) begin
        case (m_mode)
          0: begin
            e_sym = 0;
            if (m_pend) begin m_mode = 1; m_left = 16; end
            m_pend = 1'b0;
          end
          1: begin
            m_win = seq_next(m_win);
            e_sym = amp_of(m_win[1:0]);
            was_train = 1'b1;
            m_left--;
            if (m_left == 0) begin e_done = 1'b1; m_mode = 2; m_pend = 1'b0; end
          end
          default: begin
            m_win = seq_next(m_win);
            if (m_pend) begin
              m_mode = 1; m_left = 16; e_sym = amp_of(m_win[1:0]);
            end else if (dv) e_sym = amp_of(ds);
            else e_sym = amp_of(m_win[1:0]);
            m_pend = 1'b0;
          end
        endcase
      end
      m_pend = m_pend | st;
      e_act = (m_mode == 1);
    end
    #1;
    check_val("tx_sym", int'(tx_sym), e_sym);
    check_val("train_active", int'(train_active), int'(e_act));
    check_val("train_done", int'(train_done), int'(e_done));
    if (was_train) begin
      g_n++;
      g_sum += (tx_sym < 0) ? -int'(tx_sym) : int'(tx_sym);
      g_done += int'(train_done);
      if (!(tx_sym == 18'sd98304 || tx_sym == -18'sd98304 ||
            tx_sym == 18'sd32768 || tx_sym == -18'sd32768))
        check_val("train_level_set", int'(tx_sym), 98304);
      if (g_n < 16) check_val("done_early", int'(train_done), 0);
    end
  endtask

  task automatic burst_check(input string tag, input bit want_mean);
    int dev;
    check_val({tag, "_len"}, g_n, 16);
    check_val({tag, "_done_cnt"}, g_done, 1);
    if (want_mean) begin
      dev = g_sum / 16 - 65536;
      if (dev < 0) dev = -dev;
      check_val({tag, "_mean_dev_le1"}, int'(dev <= 1), 1);
    end
  endtask

  initial begin
    int guard;
    // 1: reset then idle with clk_en steady
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    check_val("rst_tx_sym", int'(tx_sym), 0);
    check_val("rst_active", int'(train_active), 0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 2'($urandom), 1'($urandom), 1'b0);

    // 2: one burst from the reset seed
    gclr();
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    burst_check("t2", 1'b1);

    // 3: all four Gray symbols, then random data/filler
    cyc(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    check_val("map_00", int'(tx_sym), -98304);
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    check_val("map_01", int'(tx_sym), -32768);
    cyc(1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
    check_val("map_11", int'(tx_sym), 32768);
    cyc(1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
    check_val("map_10", int'(tx_sym), 98304);
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 2'($urandom), 1'($urandom), 1'b0);

    // 4: sparse clk_en, start on a disabled cycle, burst still 16 enabled symbols
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    gclr();
    for (int k = 0; k < 100; k++) cyc(k % 4 == 3, k == 5, 2'($urandom), 1'($urandom), 1'b0);
    burst_check("t4", 1'b1);

    // 5: start from DATA, re-pulse at training symbol 5, no restart afterwards
    gclr();
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    guard = 0;
    while (g_n < 4 && guard < 50) begin cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0); guard++; end
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    check_val("t5_at_sym5", g_n, 5);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 2'($urandom), 1'($urandom), 1'b0);
    burst_check("t5a", 1'b0);
    check_val("t5_no_restart", int'(train_active), 0);
    gclr();
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 2'($urandom), 1'($urandom), 1'b0);
    burst_check("t5b", 1'b0);

    // 6: reset at training symbol 7, then a fresh full burst
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    gclr();
    guard = 0;
    while (g_n < 7 && guard < 50) begin cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0); guard++; end
    check_val("t6_at_sym7", g_n, 7);
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    check_val("t6_rst_tx", int'(tx_sym), 0);
    check_val("t6_rst_active", int'(train_active), 0);
    check_val("t6_rst_done", int'(train_done), 0);
    gclr();
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    burst_check("t6", 1'b1);

    // Random mix against the model
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 2'($urandom),
          1'($urandom), $urandom_range(0, 299) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
